pwm_fade_sequencer: RTL

- Sequences one `pwm` instance to produce an LED "breathing" envelope.
- Ramps the duty value up, holds it, ramps it down, holds it, then either stops or repeats.
- Advances only on PWM period boundaries, using the PWM's cycle-end strobe.
- Drives the PWM's top/compare load interface and sits between the control registers and the PWM.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_fade_sequencer_if.sv | 32 +++
 rtl/pwm_tick_divider.sv | 36 +++
 rtl/pwm_fade_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade sequencer.
// Holds the state encodings and the fade state enum used by the
// sequencer FSM.
package pwm_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RISE    = 3'd1;
    localparam logic [2:0] S_HOLD_HI = 3'd2;
    localparam logic [2:0] S_FALL    = 3'd3;
    localparam logic [2:0] S_HOLD_LO = 3'd4;

    typedef enum logic [2:0] {
        FS_IDLE    = S_IDLE,
        FS_RISE    = S_RISE,
        FS_HOLD_HI = S_HOLD_HI,
        FS_FALL    = S_FALL,
        FS_HOLD_LO = S_HOLD_LO
    } fade_state_t;

endpackage

// File: rtl/pwm_fade_sequencer_if.sv
// Load interface between the fade sequencer and one PWM instance.
//   top           : PWM period top value
//   top_valid     : one-cycle load strobe for top
//   compare       : PWM compare value (RESOLUTION+1 bits, MAX = 100%)
//   compare_valid : one-cycle load strobe for compare
//   cycle_end     : period-end strobe coming back from the PWM
// master = sequencer side, slave = PWM side.
interface pwm_fade_sequencer_if #(
    parameter int RESOLUTION = 8
);
    logic [RESOLUTION-1:0] top;
    logic                  top_valid;
    logic [RESOLUTION:0]   compare;
    logic                  compare_valid;
    logic                  cycle_end;

    modport master (
        output top,
        output top_valid,
        output compare,
        output compare_valid,
        input  cycle_end
    );

    modport slave (
        input  top,
        input  top_valid,
        input  compare,
        input  compare_valid,
        output cycle_end
    );
endinterface

// File: rtl/pwm_tick_divider.sv
// Divides PWM period-end strobes down to fade update ticks.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : holds the count at 0 and suppresses ticks
//   i_cycle_end    : PWM period-end strobe
//   i_div          : periods per tick minus 1
//   o_tick         : combinational, high in the cycle of the
//                    i_cycle_end that completes a division
module pwm_tick_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_cycle_end,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] div_cnt_reg;
    logic                 wrap;

    assign wrap   = (div_cnt_reg == i_div);
    assign o_tick = !i_clear && i_cycle_end && wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_reg <= '0;
        end else if (i_clear) begin
            div_cnt_reg <= '0;
        end else if (i_cycle_end) begin
            div_cnt_reg <= wrap ? '0 : div_cnt_reg + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// LED breathing envelope sequencer for one PWM instance.
// Ramps compare 0 -> MAX, holds, ramps back to 0, holds, then stops
// or repeats. Updates happen on divided PWM period boundaries.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start / i_stop : single-cycle control pulses (stop has priority)
//   i_top, i_step, i_div, i_hold : configuration, latched on start
//   i_repeat         : loop request, sampled when leaving HOLD_LO
//   pwm_bus          : top/compare load interface and cycle-end strobe
//   o_busy           : state != IDLE (combinational)
//   o_done           : one-cycle pulse on normal completion
module pwm_fade_sequencer #(
    parameter int RESOLUTION = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [RESOLUTION-1:0] i_top,
    input  logic [RESOLUTION-1:0] i_step,
    input  logic [DIV_WIDTH-1:0]  i_div,
    input  logic [DIV_WIDTH-1:0]  i_hold,
    input  logic                  i_repeat,
    pwm_fade_sequencer_if.master  pwm_bus,
    output logic                  o_busy,
    output logic                  o_done
);
    import pwm_pkg::*;

    localparam int CW = RESOLUTION + 1;  // compare width
    localparam int SW = RESOLUTION + 2;  // non-wrapping sum width

    fade_state_t           state_reg, state_next;
    logic [CW-1:0]         compare_reg, compare_next;
    logic [RESOLUTION-1:0] top_reg, top_next;
    logic                  top_valid_reg, top_valid_next;
    logic                  compare_valid_reg, compare_valid_next;
    logic                  done_reg, done_next;
    logic [DIV_WIDTH-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [RESOLUTION-1:0] top_l_reg, top_l_next;
    logic [RESOLUTION-1:0] step_l_reg, step_l_next;
    logic [DIV_WIDTH-1:0]  div_l_reg, div_l_next;
    logic [DIV_WIDTH-1:0]  hold_l_reg, hold_l_next;

    logic                  tick;
    logic                  div_clear;
    logic [CW-1:0]         max_val;
    logic [CW-1:0]         step_ext;
    logic [SW-1:0]         rise_sum;
    logic [CW-1:0]         rise_val;
    logic [CW-1:0]         fall_val;
    logic                  hold_last;

    // Divider only runs while a sequence is active; a stop clears it
    // in the same cycle so no stale tick can follow an abort.
    assign div_clear = (state_reg == FS_IDLE) || i_stop;

    pwm_tick_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_div (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (div_clear),
        .i_cycle_end (pwm_bus.cycle_end),
        .i_div       (div_l_reg),
        .o_tick      (tick)
    );

    // MAX is top+1 so that top=2^RESOLUTION-1 still reaches 100% duty.
    assign max_val   = {1'b0, top_l_reg} + CW'(1);
    assign step_ext  = {1'b0, step_l_reg};
    assign rise_sum  = {1'b0, compare_reg} + {2'b00, step_l_reg};
    assign rise_val  = (rise_sum >= {1'b0, max_val}) ? max_val : rise_sum[CW-1:0];
    assign fall_val  = (compare_reg <= step_ext) ? '0 : compare_reg - step_ext;
    assign hold_last = (hold_cnt_reg == hold_l_reg);

    always_comb begin
        state_next         = state_reg;
        compare_next       = compare_reg;
        top_next           = top_reg;
        top_valid_next     = 1'b0;
        compare_valid_next = 1'b0;
        done_next          = 1'b0;
        hold_cnt_next      = hold_cnt_reg;
        top_l_next         = top_l_reg;
        step_l_next        = step_l_reg;
        div_l_next         = div_l_reg;
        hold_l_next        = hold_l_reg;

        if (i_stop) begin
            state_next         = FS_IDLE;
            compare_next       = '0;
            compare_valid_next = 1'b1;
        end else begin
            case (state_reg)
                FS_IDLE: begin
                    if (i_start) begin
                        top_l_next         = i_top;
                        // A zero step would never leave RISE.
                        step_l_next        = (i_step == '0) ? RESOLUTION'(1) : i_step;
                        div_l_next         = i_div;
                        hold_l_next        = i_hold;
                        top_next           = i_top;
                        compare_next       = '0;
                        top_valid_next     = 1'b1;
                        compare_valid_next = 1'b1;
                        hold_cnt_next      = '0;
                        state_next         = FS_RISE;
                    end
                end
                FS_RISE: begin
                    if (tick) begin
                        compare_next       = rise_val;
                        compare_valid_next = 1'b1;
                        if (rise_val == max_val) begin
                            hold_cnt_next = '0;
                            state_next    = FS_HOLD_HI;
                        end
                    end
                end
                FS_HOLD_HI: begin
                    if (tick) begin
                        if (hold_last) begin
                            state_next = FS_FALL;
                        end else begin
                            hold_cnt_next = hold_cnt_reg + DIV_WIDTH'(1);
                        end
                    end
                end
                FS_FALL: begin
                    if (tick) begin
                        compare_next       = fall_val;
                        compare_valid_next = 1'b1;
                        if (fall_val == '0) begin
                            hold_cnt_next = '0;
                            state_next    = FS_HOLD_LO;
                        end
                    end
                end
                FS_HOLD_LO: begin
                    if (tick) begin
                        if (hold_last) begin
                            if (i_repeat) begin
                                state_next = FS_RISE;
                            end else begin
                                state_next = FS_IDLE;
                                done_next  = 1'b1;
                            end
                        end else begin
                            hold_cnt_next = hold_cnt_reg + DIV_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_next = FS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg         <= FS_IDLE;
            compare_reg       <= '0;
            top_reg           <= '0;
            top_valid_reg     <= 1'b0;
            compare_valid_reg <= 1'b0;
            done_reg          <= 1'b0;
            hold_cnt_reg      <= '0;
            top_l_reg         <= '0;
            step_l_reg        <= '0;
            div_l_reg         <= '0;
            hold_l_reg        <= '0;
        end else begin
            state_reg         <= state_next;
            compare_reg       <= compare_next;
            top_reg           <= top_next;
            top_valid_reg     <= top_valid_next;
            compare_valid_reg <= compare_valid_next;
            done_reg          <= done_next;
            hold_cnt_reg      <= hold_cnt_next;
            top_l_reg         <= top_l_next;
            step_l_reg        <= step_l_next;
            div_l_reg         <= div_l_next;
            hold_l_reg        <= hold_l_next;
        end
    end

    assign pwm_bus.top           = top_reg;
    assign pwm_bus.top_valid     = top_valid_reg;
    assign pwm_bus.compare       = compare_reg;
    assign pwm_bus.compare_valid = compare_valid_reg;
    assign o_busy                = (state_reg != FS_IDLE);
    assign o_done                = done_reg;

endmodule
